// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller command port between two
// masters and steers returned read words back through an in-order tag FIFO.
// Optional build macro: SDRAM_ARB_RR_EN selects round-robin tie-breaking
// (otherwise m0 has fixed priority).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant held; arbitrate between pending requests
// S_GRANT | r_gnt's command is forwarded to az_* until accepted/dropped
module sdram_port_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic [BE_W-1:0]   m0_be_n,
  input  logic              m0_rd_n,
  input  logic              m0_wr_n,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic [BE_W-1:0]   m1_be_n,
  input  logic              m1_rd_n,
  input  logic              m1_wr_n,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] az_addr,
  output logic [DATA_W-1:0] az_data,
  output logic [BE_W-1:0]   az_be_n,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic              err_underflow
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(MAX_PEND);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_gnt, w_gnt_nxt;
  logic [MAX_PEND-1:0] r_tag;
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;

  logic              w_req0, w_req1, w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [BE_W-1:0]   w_sel_be_n;
  logic              w_sel_rd, w_sel_wr;
  logic              w_full, w_empty;
  logic              w_accept, w_push, w_pop, w_head;

  assign w_req0 = ~m0_rd_n | ~m0_wr_n;
  assign w_req1 = ~m1_rd_n | ~m1_wr_n;

`ifdef SDRAM_ARB_RR_EN
  logic r_last;

  // Remember the most recent grant so the next tie goes to the other master.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && (w_req0 || w_req1)) begin
      r_last <= w_winner;
    end
  end

  assign w_winner = (w_req0 && w_req1) ? ~r_last : ~w_req0;
`else
  // Fixed priority: m1 only wins when m0 is not requesting.
  assign w_winner = ~w_req0;
`endif

  assign w_sel_addr = r_gnt ? m1_addr : m0_addr;
  assign w_sel_data = r_gnt ? m1_data : m0_data;
  assign w_sel_be_n = r_gnt ? m1_be_n : m0_be_n;
  assign w_sel_rd   = r_gnt ? ~m1_rd_n : ~m0_rd_n;
  assign w_sel_wr   = r_gnt ? ~m1_wr_n : ~m0_wr_n;

  // Stall decision deliberately uses the registered count, so a same-cycle
  // pop does not let a read in while full.
  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = za_valid & ~w_empty;
  assign w_head  = r_tag[r_rptr];

  // Next-state, command forwarding and acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    az_addr     = '0;
    az_data     = '0;
    az_be_n     = '0;
    az_rd_n     = 1'b1;
    az_wr_n     = 1'b1;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = w_winner;
        end
      end
      S_GRANT: begin
        if (w_sel_rd || w_sel_wr) begin
          az_addr = w_sel_addr;
          az_data = w_sel_data;
          az_be_n = w_sel_be_n;
          az_rd_n = ~(w_sel_rd & ~w_full);
          az_wr_n = ~w_sel_wr;
          if (((w_sel_rd & ~w_full) | w_sel_wr) && !za_waitrequest) begin
            w_accept    = 1'b1;
            w_push      = w_sel_rd;
            w_state_nxt = S_IDLE;
          end
        end else begin
          // Master abandoned its request before acceptance.
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign m0_waitrequest   = ~(w_accept & ~r_gnt);
  assign m1_waitrequest   = ~(w_accept & r_gnt);
  assign m0_readdata      = za_data;
  assign m1_readdata      = za_data;
  assign m0_readdatavalid = w_pop & ~w_head;
  assign m1_readdatavalid = w_pop & w_head;
  assign err_underflow    = r_err;

  // FSM state and grant owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  // In-order tag FIFO of outstanding reads plus sticky underflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= r_gnt;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (za_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: rule-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, and random traffic.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 22, DATA_W = 16, BE_W = 2, MAX_PEND = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [ADDR_W-1:0] m0_addr, m1_addr, az_addr;
  logic [DATA_W-1:0] m0_data, m1_data, az_data, za_data;
  logic [BE_W-1:0]   m0_be_n, m1_be_n, az_be_n;
  logic m0_rd_n, m0_wr_n, m1_rd_n, m1_wr_n;
  logic m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic m0_readdatavalid, m1_readdatavalid;
  logic az_rd_n, az_wr_n, za_valid, za_waitrequest, err_underflow;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_data(m0_data), .m0_be_n(m0_be_n), .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_addr(m1_addr), .m1_data(m1_data), .m1_be_n(m1_be_n), .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .az_addr(az_addr), .az_data(az_data), .az_be_n(az_be_n), .az_rd_n(az_rd_n), .az_wr_n(az_wr_n),
    .za_data(za_data), .za_valid(za_valid), .za_waitrequest(za_waitrequest),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant (-1 = none), queue of read owners.
  int mg   = -1;
  int last = 1;
  int q[$];
  bit merr = 1'b0;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic e_rd_n, e_wr_n, e_w0, e_w1, e_v0, e_v1;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [BE_W-1:0]   e_be;
    bit rq0, rq1, srd, swr, stall, acc;
    int win;
    e_rd_n = 1; e_wr_n = 1; e_w0 = 1; e_w1 = 1; e_v0 = 0; e_v1 = 0;
    e_addr = '0; e_data = '0; e_be = '0;
    acc = 0; srd = 0; swr = 0; win = 0; stall = 0;
    rq0 = !m0_rd_n || !m0_wr_n;
    rq1 = !m1_rd_n || !m1_wr_n;
    if (!reset_n) begin
      mg = -1; last = 1; q.delete(); merr = 0;
    end else begin
      if (mg >= 0) begin
        srd = (mg == 0) ? !m0_rd_n : !m1_rd_n;
        swr = (mg == 0) ? !m0_wr_n : !m1_wr_n;
        if (srd || swr) begin
          stall  = srd && (q.size() == MAX_PEND);
          e_addr = (mg == 0) ? m0_addr : m1_addr;
          e_data = (mg == 0) ? m0_data : m1_data;
          e_be   = (mg == 0) ? m0_be_n : m1_be_n;
          e_rd_n = !(srd && !stall);
          e_wr_n = !swr;
          acc    = ((srd && !stall) || swr) && !za_waitrequest;
          if (acc && mg == 0) e_w0 = 0;
          if (acc && mg == 1) e_w1 = 0;
        end
      end
      if (za_valid && q.size() > 0) begin
        if (q[0] == 0) e_v0 = 1; else e_v1 = 1;
      end
    end
    chk("az_rd_n", az_rd_n, e_rd_n);
    chk("az_wr_n", az_wr_n, e_wr_n);
    chk("az_addr", az_addr, e_addr);
    chk("az_data", az_data, e_data);
    chk("az_be_n", az_be_n, e_be);
    chk("m0_waitrequest", m0_waitrequest, e_w0);
    chk("m1_waitrequest", m1_waitrequest, e_w1);
    chk("m0_readdatavalid", m0_readdatavalid, e_v0);
    chk("m1_readdatavalid", m1_readdatavalid, e_v1);
    chk("m0_readdata", m0_readdata, za_data);
    chk("m1_readdata", m1_readdata, za_data);
    chk("err_underflow", err_underflow, merr);
    if (reset_n) begin
      if (za_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (acc && srd) q.push_back(mg);
      if (mg < 0) begin
        if (rq0 || rq1) begin
`ifdef SDRAM_ARB_RR_EN
          win = (rq0 && rq1) ? 1 - last : (rq0 ? 0 : 1);
`else
          win = rq0 ? 0 : 1;
`endif
          mg = win; last = win;
        end
      end else if (acc || !(srd || swr)) begin
        mg = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_masters();
    m0_rd_n = 1; m0_wr_n = 1; m1_rd_n = 1; m1_wr_n = 1;
  endtask

  task automatic do_reset();
    reset_n = 0; idle_masters();
    za_valid = 0; za_waitrequest = 0; za_data = '0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic new_cmd(input int i);
    bit rd;
    rd = $urandom_range(1, 0) == 1;
    if (i == 0) begin
      m0_addr = ADDR_W'($urandom); m0_data = DATA_W'($urandom); m0_be_n = BE_W'($urandom);
      m0_rd_n = !rd; m0_wr_n = rd;
    end else begin
      m1_addr = ADDR_W'($urandom); m1_data = DATA_W'($urandom); m1_be_n = BE_W'($urandom);
      m1_rd_n = !rd; m1_wr_n = rd;
    end
  endtask

  task automatic drop_cmd(input int i);
    if (i == 0) begin m0_rd_n = 1; m0_wr_n = 1; end
    else begin m1_rd_n = 1; m1_wr_n = 1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g[$];
    int own[$];
    int exp_g[6];
    int acc_cnt;
    bit a[2];
    bit act;

    // Reset with both masters requesting.
    reset_n = 0; za_valid = 0; za_waitrequest = 0; za_data = '0;
    m0_addr = 22'h000111; m0_data = '0; m0_be_n = '0; m0_rd_n = 0; m0_wr_n = 1;
    m1_addr = 22'h000222; m1_data = '0; m1_be_n = '0; m1_rd_n = 0; m1_wr_n = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_az_rd_n", az_rd_n, 1'b1);
    chk("rst_az_wr_n", az_wr_n, 1'b1);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_readdata", m0_readdata, 16'h0000);
    tick(); reset_n = 1;
    @(negedge clk);
    chk("arb_cycle_az_rd_n", az_rd_n, 1'b1);
    tick();
    @(negedge clk);
    chk("first_cmd_az_rd_n", az_rd_n, 1'b0);
    chk("first_cmd_addr", az_addr, 22'h000111);
    chk("first_cmd_m0_wait", m0_waitrequest, 1'b0);
    chk("first_cmd_m1_wait", m1_waitrequest, 1'b1);
    tick(); idle_masters();
    za_valid = 1; za_data = 16'h1234;
    @(negedge clk);
    chk("first_ret_m0_v", m0_readdatavalid, 1'b1);
    chk("first_ret_m1_v", m1_readdatavalid, 1'b0);
    chk("first_ret_data", m0_readdata, 16'h1234);
    tick(); za_valid = 0;

    // Single write from m0.
    m0_addr = 22'h00BABE; m0_data = 16'hD00D; m0_be_n = 2'b00; m0_wr_n = 0;
    tick();
    @(negedge clk);
    chk("wr_az_wr_n", az_wr_n, 1'b0);
    chk("wr_az_rd_n", az_rd_n, 1'b1);
    chk("wr_az_addr", az_addr, 22'h00BABE);
    chk("wr_az_data", az_data, 16'hD00D);
    chk("wr_m0_wait", m0_waitrequest, 1'b0);
    tick(); m0_wr_n = 1;
    @(negedge clk);
    chk("wr_one_cycle", az_wr_n, 1'b1);
    tick();

    // Contention: both masters issue reads continuously.
    do_reset();
    m0_addr = 22'h000A00; m1_addr = 22'h000B00;
    m0_rd_n = 0; m1_rd_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!m0_waitrequest) g.push_back(0);
      else if (!m1_waitrequest) g.push_back(1);
      tick();
    end
    idle_masters();
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    chk("grant_count", g.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < g.size()) chk($sformatf("grant_%0d", i), g[i], exp_g[i]);
    end
    for (int i = 0; i < 6; i++) begin
      za_valid = 1; za_data = DATA_W'(16'h0100 + i);
      @(negedge clk);
      own.push_back(m1_readdatavalid ? 1 : (m0_readdatavalid ? 0 : -1));
      tick();
    end
    za_valid = 0;
    for (int i = 0; i < 6; i++) chk($sformatf("return_owner_%0d", i), own[i], exp_g[i]);

    // FIFO full: ninth read stalls until a pop frees a slot.
    do_reset();
    m0_addr = 22'h003000; m0_rd_n = 0;
    acc_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!m0_waitrequest) acc_cnt++;
      if (acc_cnt == 8) break;
      tick();
    end
    chk("full_accepts", acc_cnt, 8);
    tick(); tick();
    @(negedge clk);
    chk("full_stall_rd_n", az_rd_n, 1'b1);
    chk("full_stall_wait", m0_waitrequest, 1'b1);
    tick();
    za_valid = 1; za_data = 16'hBEEF;
    @(negedge clk);
    chk("full_pop_cycle_rd_n", az_rd_n, 1'b1);
    chk("full_pop_cycle_v", m0_readdatavalid, 1'b1);
    tick(); za_valid = 0;
    @(negedge clk);
    chk("full_after_pop_rd_n", az_rd_n, 1'b0);
    chk("full_after_pop_wait", m0_waitrequest, 1'b0);
    tick(); m0_rd_n = 1;
    for (int i = 0; i < 8; i++) begin
      za_valid = 1; za_data = DATA_W'($urandom);
      tick();
    end
    za_valid = 0;
    tick();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a[0] = !m0_waitrequest; a[1] = !m1_waitrequest;
      tick();
      for (int i = 0; i < 2; i++) begin
        act = (i == 0) ? (!m0_rd_n || !m0_wr_n) : (!m1_rd_n || !m1_wr_n);
        if (act && a[i]) begin
          if ($urandom_range(1, 0) == 1) new_cmd(i); else drop_cmd(i);
        end else if (act) begin
          if ($urandom_range(31, 0) == 0) drop_cmd(i);
        end else if ($urandom_range(9, 0) < 4) begin
          new_cmd(i);
        end
      end
      za_waitrequest = ($urandom_range(9, 0) < 3);
      za_valid = (q.size() > 0) && ($urandom_range(9, 0) < 4);
      za_data = DATA_W'($urandom);
    end
    idle_masters(); za_valid = 0; za_waitrequest = 0;
    tick();

    // Reset with a read in flight, then its late return underflows.
    do_reset();
    m0_addr = 22'h000777; m0_rd_n = 0;
    tick();
    @(negedge clk);
    chk("inflight_accept", m0_waitrequest, 1'b0);
    tick(); m0_rd_n = 1;
    reset_n = 0;
    tick(); reset_n = 1;
    za_valid = 1; za_data = 16'h5A5A;
    @(negedge clk);
    chk("uflow_m0_v", m0_readdatavalid, 1'b0);
    chk("uflow_m1_v", m1_readdatavalid, 1'b0);
    chk("uflow_err_before", err_underflow, 1'b0);
    tick(); za_valid = 0;
    @(negedge clk);
    chk("uflow_err_set", err_underflow, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("uflow_err_sticky", err_underflow, 1'b1);
    tick(); reset_n = 0;
    @(negedge clk);
    chk("uflow_err_cleared", err_underflow, 1'b0);
    tick(); reset_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master arbiter in front of the SDRAM controller's Avalon-MM slave port (az_*/za_* signals). It shares the single controller command port between two requesters, such as a CPU data master and a DMA engine. It tracks outstanding reads in an in-order tag FIFO and routes each returned read word to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 22, word address width (matches az_addr)
- DATA_W, 16, data width
- BE_W, 2, byte-enable width (active-low, drives az_be_n)
- MAX_PEND, 8, tag FIFO depth: max outstanding reads (power of 2, >=2)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- mN_addr  in  ADDR_W  master N address, N = 0,1
- mN_data  in  DATA_W  master N write data
- mN_be_n  in  BE_W  master N byte enables, active-low
- mN_rd_n, mN_wr_n  in  1 each  master N read/write strobes, active-low, mutually exclusive
- mN_waitrequest  out  1  high = master N command not accepted this cycle
- mN_readdata  out  DATA_W  read data for master N
- mN_readdatavalid  out  1  one-cycle pulse per returned word
- az_addr, az_data, az_be_n, az_rd_n, az_wr_n  out  as above  to controller
- za_data  in  DATA_W; za_valid  in  1; za_waitrequest  in  1  from controller
- err_underflow  out  1  sticky: za_valid seen with tag FIFO empty

## Operation
- FSM states: IDLE, GRANT.
- IDLE → GRANT: any mN_rd_n or mN_wr_n is low. The winner is registered into `gnt`.
- GRANT: the granted master's addr/data/be_n/rd_n/wr_n are forwarded combinationally to az_*.
- Acceptance = az strobe low AND za_waitrequest low.
- On acceptance, the granted master's waitrequest is low for that cycle. A read pushes tag `gnt` into the FIFO. FSM returns to IDLE.
- Non-granted master: waitrequest held high at all times.
- Granted master drops its strobe before acceptance (protocol violation): GRANT → IDLE, nothing forwarded.
- Read stall: granted command is a read and the FIFO is full. az_rd_n is held high and the master's waitrequest stays high until a pop frees a slot.
- Writes are never stalled by the FIFO.
- Return path: za_valid pops the FIFO head. za_data goes to both mN_readdata; only the head-tag owner gets readdatavalid.
- za_valid with FIFO empty: word is dropped, err_underflow set. Cleared only by reset.
- Same-cycle push and pop with the FIFO full: the pop frees the slot but the push is still refused this cycle. Stall decision uses the registered count.
- Same-cycle push and pop, not full: count unchanged, pointers both advance (mod MAX_PEND).

## Timing
- Reset values:
  - FSM IDLE, gnt=0, FIFO empty.
  - az_rd_n=1, az_wr_n=1, az_addr/az_data=0, az_be_n=0.
  - m0/m1_waitrequest=1, readdatavalid=0, readdata=0, err_underflow=0.
- Arbitration latency: request at cycle N (FSM in IDLE) → az command valid at N+1. Minimum 2 cycles per accepted command, so peak throughput is one command every 2 cycles.
- Read return: zero added latency. mN_readdatavalid and mN_readdata are combinational from za_valid/za_data in the same cycle.
- Reset mid-operation: all state clears immediately. Reads in flight at the controller are not tracked. Their later za_valid pulses set err_underflow; the system resets the controller together with this block.

## Configuration
- SDRAM_ARB_RR_EN defined:
  - Round-robin. A `last` register records the master granted most recently.
  - On simultaneous requests, the other master wins.
  - `last` resets to 1, so m0 wins the first tie.
- Not defined: fixed priority, m0 always wins ties. m1 can starve; this is intended for a low-rate secondary master.

## Test plan
- Reset: hold reset_n=0 with both masters requesting → az_rd_n=az_wr_n=1, both waitrequest=1, err_underflow=0. Release → first az command is valid 1 cycle after arbitration.
- Single write: m0 writes addr 0x00BABE, data 0xD00D, za_waitrequest=0 → az_addr=0x00BABE, az_data=0xD00D, az_wr_n=0 for one cycle. m0_waitrequest is low in that cycle; the FIFO stays empty.
- Contention with SDRAM_ARB_RR_EN: both masters issue continuous reads → grants alternate m0, m1, m0, m1. Each za_valid returns data to the correct master in issue order.
- Contention without the macro: the same stimulus → m0 is granted every time and m1_waitrequest stays high.
- FIFO full: m0 issues 9 reads with za_valid held low (MAX_PEND=8) → the 9th read stalls with az_rd_n=1. One za_valid pulse → the 9th read is accepted on the following cycle.
- Underflow: pulse za_valid with no reads outstanding → no readdatavalid on either master, and err_underflow=1 until reset.
